// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment score display: BCD type and segment decode.
package ssd_pkg;

    typedef logic [3:0] bcd_t;

    // All cathodes off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {a,b,c,d,e,f,g} patterns for digits 0..9.
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    // Decode one BCD digit; non-decimal codes blank the digit.
    function automatic logic [6:0] seg_decode(input bcd_t digit);
        logic [6:0] segs;
        segs = SEG_BLANK;
        if (digit < 4'd10) begin
            segs = SEG_TABLE[digit];
        end
        return segs;
    endfunction

endpackage

// File: rtl/ssd_bcd_counter.sv
// Multi-digit ripple-carry BCD score counter with clear and sticky overflow.
module ssd_bcd_counter
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inc,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    overflow
);

    logic [4*NUM_DIGITS-1:0] bcd_nxt;
    logic                    carry;
    logic                    carry_out;

    // Ripple the increment through the digits; a 9 wraps to 0 and passes the carry up.
    always_comb begin
        bcd_nxt = bcd;
        carry   = inc;
        for (int d = 0; d < int'(NUM_DIGITS); d++) begin
            if (carry) begin
                if (bcd_t'(bcd[d*4 +: 4]) == bcd_t'(4'd9)) begin
                    bcd_nxt[d*4 +: 4] = 4'd0;
                end else begin
                    bcd_nxt[d*4 +: 4] = bcd[d*4 +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        carry_out = carry;
    end

    // Score and overflow registers; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            bcd <= bcd_nxt;
            if (carry_out) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssd_score_scanner.sv
// N-digit BCD score display: counts score pulses and time-multiplexes digits onto shared cathodes.
module ssd_score_scanner
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned SCAN_DIV_BITS = 18,
    parameter int unsigned DEAD_CYCLES   = 16,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    score_inc,
    input  logic                    score_clr,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic                    overflow
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [SCAN_DIV_BITS-1:0] presc;
    logic [IDX_W-1:0]         idx;
    logic [NUM_DIGITS-1:0]    upper_zero;
    logic [NUM_DIGITS-1:0]    blank_vec;
    logic                     lz_acc;
    bcd_t                     cur_digit;
    logic                     cur_blank;
    logic                     cur_dp;
    logic                     in_dead;
    logic [NUM_DIGITS-1:0]    an_c;
    logic [6:0]               seg_c;
    logic                     dp_c;

    ssd_bcd_counter #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .inc      (score_inc),
        .clr      (score_clr),
        .bcd      (score_bcd),
        .overflow (overflow)
    );

    // Dwell prescaler and digit index; index steps when the prescaler rolls over.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= presc + SCAN_DIV_BITS'(1);
            if (&presc) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // upper_zero[d] is set when digits d..top are all zero.
    always_comb begin
        upper_zero = '0;
        lz_acc     = 1'b1;
        for (int d = int'(NUM_DIGITS) - 1; d >= 0; d--) begin
            lz_acc        = lz_acc & (score_bcd[d*4 +: 4] == 4'd0);
            upper_zero[d] = lz_acc;
        end
    end

    // Per-digit blanking: disabled digits, plus leading zeros above digit 0.
    always_comb begin
        blank_vec = ~digit_en;
        if (BLANK_LEADING != 0) begin
            for (int d = 1; d < int'(NUM_DIGITS); d++) begin
                blank_vec[d] = blank_vec[d] | upper_zero[d];
            end
        end
    end

    // Select the digit under the scan index.
    always_comb begin
        cur_digit = '0;
        cur_blank = 1'b1;
        cur_dp    = 1'b0;
        for (int d = 0; d < int'(NUM_DIGITS); d++) begin
            if (IDX_W'(d) == idx) begin
                cur_digit = bcd_t'(score_bcd[d*4 +: 4]);
                cur_blank = blank_vec[d];
                cur_dp    = dp_mask[d];
            end
        end
    end

    // Next display drive: dark during dead time or when blanked, else one anode lit.
    always_comb begin
        an_c    = '1;
        seg_c   = SEG_BLANK;
        dp_c    = 1'b1;
        in_dead = (32'(presc) < DEAD_CYCLES);
        if (!in_dead && !cur_blank) begin
            an_c  = ~(NUM_DIGITS'(1) << idx);
            seg_c = seg_decode(cur_digit);
            dp_c  = ~cur_dp;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_c;
            seg <= seg_c;
            dp  <= dp_c;
        end
    end

endmodule

// File: tb/tb_ssd_score_scanner.sv
// Directed bench for ssd_score_scanner with a short scan period.
module tb_ssd_score_scanner;

    localparam int unsigned N      = 4;
    localparam int unsigned DIVB   = 3;
    localparam int unsigned DEAD   = 2;
    localparam int          PERIOD = 1 << DIVB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          score_inc = 1'b0;
    logic          score_clr = 1'b0;
    logic [N-1:0]  digit_en = 4'hF;
    logic [N-1:0]  dp_mask = 4'h0;
    logic [N-1:0]  an;
    logic [6:0]    seg;
    logic          dp;
    logic [4*N-1:0] score_bcd;
    logic          overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int out_p = 0;
    int out_i = 0;
    bit out_rst = 1'b1;

    ssd_score_scanner #(
        .NUM_DIGITS    (N),
        .SCAN_DIV_BITS (DIVB),
        .DEAD_CYCLES   (DEAD),
        .BLANK_LEADING (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .score_inc (score_inc),
        .score_clr (score_clr),
        .digit_en  (digit_en),
        .dp_mask   (dp_mask),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .score_bcd (score_bcd),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock; records which prescaler/index the freshly registered outputs reflect.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            out_rst = 1'b1;
            cyc     = 0;
        end else begin
            out_rst = 1'b0;
            out_p   = cyc % PERIOD;
            out_i   = (cyc / PERIOD) % int'(N);
            cyc++;
        end
        #1;
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            score_inc = 1'b1;
            tick();
        end
        score_inc = 1'b0;
    endtask

    // Check n cycles of scan output; lit/segs/dpn give the hand-decoded view per digit.
    task automatic run_scan(input int n, input logic [3:0] lit, input logic [27:0] segs,
                            input logic [3:0] dpn);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        for (int k = 0; k < n; k++) begin
            tick();
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
            if (!out_rst && out_p >= int'(DEAD) && lit[out_i]) begin
                e_an  = ~(4'b0001 << out_i);
                e_seg = segs[out_i*7 +: 7];
                e_dp  = dpn[out_i];
            end
            check("scan_an",  32'(an),  32'(e_an));
            check("scan_seg", 32'(seg), 32'(e_seg));
            check("scan_dp",  32'(dp),  32'(e_dp));
        end
    endtask

    initial begin
        int guard;

        // Reset values
        reset = 1'b1;
        tick();
        tick();
        check("rst_an",  32'(an),        32'h0000000F);
        check("rst_seg", 32'(seg),       32'h0000007F);
        check("rst_dp",  32'(dp),        32'h1);
        check("rst_score", 32'(score_bcd), 32'h0);
        check("rst_ovf", 32'(overflow),  32'h0);
        reset = 1'b0;

        // Idle: only digit 0 shows '0'
        run_scan(40, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 4'hF);
        check("idle_score", 32'(score_bcd), 32'h0);
        check("idle_ovf",   32'(overflow),  32'h0);

        // 123 pulses: "123" with digit 3 blanked
        pulse_inc(123);
        check("s123", 32'(score_bcd), 32'h0123);
        run_scan(40, 4'b0111, {7'h7F, 7'b1001111, 7'b0010010, 7'b0000110}, 4'hF);

        // Fill to 9999, then wrap and set overflow
        pulse_inc(9999 - 123);
        check("s9999",     32'(score_bcd), 32'h9999);
        check("s9999_ovf", 32'(overflow),  32'h0);
        pulse_inc(1);
        check("wrap_score", 32'(score_bcd), 32'h0);
        check("wrap_ovf",   32'(overflow),  32'h1);
        pulse_inc(1);
        check("sticky_score", 32'(score_bcd), 32'h1);
        check("sticky_ovf",   32'(overflow),  32'h1);
        score_clr = 1'b1;
        tick();
        score_clr = 1'b0;
        check("clr_score", 32'(score_bcd), 32'h0);
        check("clr_ovf",   32'(overflow),  32'h0);

        // Clear beats a simultaneous increment
        pulse_inc(5);
        check("s5", 32'(score_bcd), 32'h5);
        score_inc = 1'b1;
        score_clr = 1'b1;
        tick();
        score_inc = 1'b0;
        score_clr = 1'b0;
        check("clr_pri", 32'(score_bcd), 32'h0);
        tick();
        check("clr_pri_hold", 32'(score_bcd), 32'h0);

        // Digit 0 disabled: everything dark
        pulse_inc(7);
        digit_en = 4'b1110;
        dp_mask  = 4'b0001;
        run_scan(40, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'b0001111}, 4'b1110);
        // Digit 0 enabled: '7' with decimal point
        digit_en = 4'b1111;
        run_scan(40, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'b0001111}, 4'b1110);
        dp_mask = 4'b0000;

        // Reset mid-dwell while index 2 is on screen
        guard = 0;
        while (!(out_i == 2 && out_p == 4) && guard < 64) begin
            tick();
            guard++;
        end
        check("align_idx2", 32'(guard < 64), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_an",    32'(an),        32'h0000000F);
        check("mid_rst_seg",   32'(seg),       32'h0000007F);
        check("mid_rst_dp",    32'(dp),        32'h1);
        check("mid_rst_score", 32'(score_bcd), 32'h0);
        tick();
        check("dead0_an", 32'(an), 32'h0000000F);
        tick();
        check("dead1_an", 32'(an), 32'h0000000F);
        tick();
        check("relit_an",  32'(an),  32'h0000000E);
        check("relit_seg", 32'(seg), 32'h00000001);
        run_scan(16, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
